// File: rtl/interp_pkg.sv
// Shared definitions for the interpolating upsampler.
// Contents:
//   state_t / St*  : controller state encodings (legacy-compatible constants)
//   RECIP_ONE      : 2^16, the reciprocal for Ratio=1 at the default FRAC_W
//   recip_one()    : 2^frac_w for other fractional widths
//   sat_trunc()    : saturate an integer to a signed in_w range, keep the top out_w bits
package interp_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFill0  = 3'd1;
  localparam state_t StFill1  = 3'd2;
  localparam state_t StRun    = 3'd3;
  localparam state_t StStarve = 3'd4;

  localparam int unsigned DefFracW  = 16;
  localparam logic [DefFracW:0] RECIP_ONE = 17'h1_0000;

  function automatic logic [63:0] recip_one(input int unsigned frac_w);
    return 64'd1 << frac_w;
  endfunction

  // v is the sign-extended integer part of the accumulator. The result holds the code in its
  // low out_w bits; higher bits are sign copies and are ignored by the caller.
  function automatic logic [63:0] sat_trunc(input logic signed [63:0] v,
                                            input int unsigned in_w,
                                            input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] s;
    hi = (64'sd1 <<< (in_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (in_w - 1));
    if (v > hi) begin
      s = hi;
    end else if (v < lo) begin
      s = lo;
    end else begin
      s = v;
    end
    return s >>> (in_w - out_w);
  endfunction

endpackage

// File: rtl/interp_upsampler_out_stage.sv
// Output stage: saturates the accumulator integer part, truncates to the DAC code width,
// optionally converts to offset binary and registers the result.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   emit_i        : capture int_i this cycle; valid_o pulses next cycle
//   int_i         : accumulator integer part (signed, IN_W+2 bits)
//   valid_o       : one-cycle pulse, data_o updated
//   data_o        : output code, held between pulses
module interp_out_stage
  import interp_pkg::*;
#(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 12,
  parameter int unsigned OFFSET_BIN = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             emit_i,
  input  logic [IN_W+1:0]  int_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o
);

  logic [63:0]      int_ext;
  logic [63:0]      sat;
  logic [OUT_W-1:0] code_d;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic             unused_sat_hi;

  always_comb begin
    int_ext = {{(64 - IN_W - 2){int_i[IN_W+1]}}, int_i};
    sat     = sat_trunc(int_ext, IN_W, OUT_W);
    code_d  = sat[OUT_W-1:0];
    if (OFFSET_BIN != 0) begin
      code_d[OUT_W-1] = ~code_d[OUT_W-1];
    end
  end

  assign unused_sat_hi = ^sat[63:OUT_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= emit_i;
      if (emit_i) begin
        data_q <= code_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/interp_upsampler.sv
// Linear-interpolating upsampler for the DDS output path. Each accepted input sample starts a
// segment of Ratio output points, one per Tick; the accumulator reloads exactly from the sample
// value at every segment boundary so rounding error in Recip never accumulates.
// Ports:
//   Fg_clk, Resetn      : clock, asynchronous active-low reset
//   Enable              : run request (level); dropping it aborts to idle
//   Tick                : output-rate strobe
//   Ratio, Recip        : points per sample and round(2^FRAC_W/Ratio), latched per segment
//   S_valid/S_ready/S_data : signed sample stream
//   Out_valid, InterpOut: output pulse and code
//   Underrun            : sticky, a segment ended without a next sample
module interp_upsampler
  import interp_pkg::*;
#(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 12,
  parameter int unsigned FRAC_W     = 16,
  parameter int unsigned RATIO_W    = 16,
  parameter int unsigned OFFSET_BIN = 1
) (
  input  logic               Fg_clk,
  input  logic               Resetn,
  input  logic               Enable,
  input  logic               Tick,
  input  logic [RATIO_W-1:0] Ratio,
  input  logic [FRAC_W:0]    Recip,
  input  logic               S_valid,
  output logic               S_ready,
  input  logic [IN_W-1:0]    S_data,
  output logic               Out_valid,
  output logic [OUT_W-1:0]   InterpOut,
  output logic               Underrun
);

  localparam int unsigned AccW = IN_W + FRAC_W + 2;

  state_t                  state_q, state_d;
  logic [IN_W-1:0]         prev_q, prev_d;
  logic [IN_W-1:0]         cur_q, cur_d;
  logic [IN_W-1:0]         nxt_q, nxt_d;
  logic                    nxt_full_q, nxt_full_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [RATIO_W-1:0]      cnt_q, cnt_d;
  logic [RATIO_W-1:0]      r_ratio_q, r_ratio_d;
  logic [FRAC_W:0]         r_recip_q, r_recip_d;
  logic                    underrun_q, underrun_d;

  logic                    xfer;
  logic                    emit;
  logic                    seg_end;
  logic [RATIO_W-1:0]      last_cnt;
  logic signed [IN_W:0]    diff;
  logic [AccW-1:0]         diff_ext;
  logic [AccW-1:0]         recip_ext;
  logic [AccW-1:0]         step;

  function automatic logic signed [AccW-1:0] to_acc(input logic [IN_W-1:0] s);
    return {{2{s[IN_W-1]}}, s, {FRAC_W{1'b0}}};
  endfunction

  always_comb begin
    unique case (state_q)
      StFill0, StFill1, StStarve: S_ready = Enable;
      StRun:                      S_ready = Enable & ~nxt_full_q;
      default:                    S_ready = 1'b0;
    endcase
  end

  assign xfer = S_valid & S_ready;

  // Ratio of 0 behaves as 1: every Tick ends a segment.
  assign last_cnt = (r_ratio_q == '0) ? '0 : r_ratio_q - RATIO_W'(1);
  assign seg_end  = (cnt_q == last_cnt);

  // Width-extended operands make the modular product equal the true signed product.
  assign diff      = $signed({cur_q[IN_W-1], cur_q}) - $signed({prev_q[IN_W-1], prev_q});
  assign diff_ext  = {{(AccW - IN_W - 1){diff[IN_W]}}, diff};
  assign recip_ext = {{(AccW - FRAC_W - 1){1'b0}}, r_recip_q};
  assign step      = diff_ext * recip_ext;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    r_ratio_d  = r_ratio_q;
    r_recip_d  = r_recip_q;
    underrun_d = underrun_q;
    emit       = 1'b0;

    if (state_q != StIdle && !Enable) begin
      state_d    = StIdle;
      nxt_full_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Enable) begin
            state_d    = StFill0;
            underrun_d = 1'b0;
          end
        end
        StFill0: begin
          if (xfer) begin
            prev_d  = S_data;
            state_d = StFill1;
          end
        end
        StFill1: begin
          if (xfer) begin
            cur_d     = S_data;
            acc_d     = to_acc(prev_q);
            cnt_d     = '0;
            r_ratio_d = Ratio;
            r_recip_d = Recip;
            state_d   = StRun;
          end
        end
        StRun: begin
          if (Tick) begin
            emit = 1'b1;
            if (seg_end) begin
              prev_d = cur_q;
              acc_d  = to_acc(cur_q);
              cnt_d  = '0;
              if (nxt_full_q || xfer) begin
                // A sample arriving on the boundary cycle bypasses nxt straight into cur.
                cur_d      = nxt_full_q ? nxt_q : S_data;
                nxt_full_d = 1'b0;
                r_ratio_d  = Ratio;
                r_recip_d  = Recip;
              end else begin
                underrun_d = 1'b1;
                state_d    = StStarve;
              end
            end else begin
              acc_d = acc_q + step;
              cnt_d = cnt_q + RATIO_W'(1);
            end
          end
          if (xfer && !(Tick && seg_end)) begin
            nxt_d      = S_data;
            nxt_full_d = 1'b1;
          end
        end
        StStarve: begin
          // acc already holds the old cur (now prev), so Ticks repeat it.
          emit = Tick;
          if (xfer) begin
            cur_d     = S_data;
            acc_d     = to_acc(prev_q);
            cnt_d     = '0;
            r_ratio_d = Ratio;
            r_recip_d = Recip;
            state_d   = StRun;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      r_ratio_q  <= '0;
      r_recip_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      r_ratio_q  <= r_ratio_d;
      r_recip_q  <= r_recip_d;
      underrun_q <= underrun_d;
    end
  end

  assign Underrun = underrun_q;

  interp_out_stage #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .OFFSET_BIN(OFFSET_BIN)
  ) u_out_stage (
    .clk_i  (Fg_clk),
    .rst_ni (Resetn),
    .emit_i (emit),
    .int_i  (acc_q[AccW-1:FRAC_W]),
    .valid_o(Out_valid),
    .data_o (InterpOut)
  );

endmodule

// File: tb/tb_interp_upsampler.sv
module tb_interp_upsampler;
  import interp_pkg::*;

  logic        Fg_clk  = 1'b0;
  logic        Resetn  = 1'b0;
  logic        Enable  = 1'b0;
  logic        Tick    = 1'b0;
  logic [15:0] Ratio   = '0;
  logic [16:0] Recip   = '0;
  logic        S_valid = 1'b0;
  logic        S_ready;
  logic [31:0] S_data  = '0;
  logic        Out_valid;
  logic [11:0] InterpOut;
  logic        Underrun;

  interp_upsampler dut (
    .Fg_clk   (Fg_clk),
    .Resetn   (Resetn),
    .Enable   (Enable),
    .Tick     (Tick),
    .Ratio    (Ratio),
    .Recip    (Recip),
    .S_valid  (S_valid),
    .S_ready  (S_ready),
    .S_data   (S_data),
    .Out_valid(Out_valid),
    .InterpOut(InterpOut),
    .Underrun (Underrun)
  );

  always #5 Fg_clk = ~Fg_clk;

  int          checks = 0;
  int          errors = 0;
  int          stalls = 0;
  logic [31:0] feed[$];
  logic [31:0] accepted[$];
  logic [11:0] outs[$];

  typedef struct {
    string            name;
    logic [15:0]      ratio;
    logic [16:0]      recip;
    logic [0:2][31:0] s;
    logic [0:4][11:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    S_valid = (feed.size() != 0);
    S_data  = (feed.size() != 0) ? feed[0] : '0;
  endtask

  // One clock: sample at the falling edge, update inputs 1 ns after the rising edge.
  task automatic step();
    bit x;
    x = 1'b0;
    @(negedge Fg_clk);
    if (Out_valid) outs.push_back(InterpOut);
    if (S_valid && S_ready) begin
      accepted.push_back(S_data);
      x = 1'b1;
    end
    if (S_valid && !S_ready) stalls++;
    @(posedge Fg_clk);
    #1;
    if (x && feed.size() != 0) void'(feed.pop_front());
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic restart(input logic [15:0] r, input logic [16:0] rc);
    Enable = 1'b0;
    feed.delete();
    drive();
    steps(2);
    outs.delete();
    accepted.delete();
    stalls = 0;
    Ratio  = r;
    Recip  = rc;
    Tick   = 1'b1;
    Enable = 1'b1;
  endtask

  task automatic wait_accepts(input int n);
    for (int i = 0; i < 60 && accepted.size() < n; i++) step();
    chk("accept_count_reached", (accepted.size() >= n), 1);
  endtask

  function automatic logic [11:0] code_of(input logic [31:0] v);
    return {~v[31], v[30:20]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"ramp", 16'd4, 17'h04000,
                {32'h0000_0000, 32'h4000_0000, 32'h4000_0000},
                {12'h800, 12'h900, 12'hA00, 12'hB00, 12'hC00}};
    vecs[1] = '{"ratio1", 16'd1, RECIP_ONE,
                {32'h7FF0_0000, 32'h8000_0000, 32'h7FF0_0000},
                {12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF}};
    vecs[2] = '{"ratio0", 16'd0, 17'h10000,
                {32'h1000_0000, 32'h2000_0000, 32'h3000_0000},
                {12'h900, 12'hA00, 12'hB00, 12'hB00, 12'hB00}};
    vecs[3] = '{"neg_ramp", 16'd4, 17'h04000,
                {32'h4000_0000, 32'hC000_0000, 32'hC000_0000},
                {12'hC00, 12'hA00, 12'h800, 12'h600, 12'h400}};
    vecs[4] = '{"sat_pos", 16'd2, 17'h1FFFF,
                {32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                {12'h800, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}};
    vecs[5] = '{"sat_neg", 16'd2, 17'h1FFFF,
                {32'h0000_0000, 32'h8000_0000, 32'h8000_0000},
                {12'h800, 12'h000, 12'h000, 12'h000, 12'h000}};

    // Reset values.
    #12;
    chk("rst_s_ready", S_ready, 0);
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_interp_out", InterpOut, 0);
    chk("rst_underrun", Underrun, 0);
    @(negedge Fg_clk);
    Resetn = 1'b1;
    step();

    // Table: one refill per vector, Tick every cycle, first five output points.
    foreach (vecs[v]) begin
      restart(vecs[v].ratio, vecs[v].recip);
      for (int i = 0; i < 3; i++) feed.push_back(vecs[v].s[i]);
      drive();
      steps(24);
      chk({vecs[v].name, "_count"}, (outs.size() >= 5), 1);
      for (int i = 0; i < 5 && i < outs.size(); i++) begin
        chk($sformatf("%s_pt%0d", vecs[v].name, i), outs[i], vecs[v].exp[i]);
      end
    end

    // Underrun: two samples only, then a late third sample.
    restart(16'd4, 17'h04000);
    feed.push_back(32'h0000_0000);
    feed.push_back(32'h4000_0000);
    drive();
    wait_accepts(2);
    steps(3);
    chk("underrun_before_end", Underrun, 0);
    step();
    chk("underrun_at_end", Underrun, 1);
    steps(4);
    chk("starve_hold_out", InterpOut, 12'hC00);
    chk("starve_seg_count", outs.size() >= 4, 1);
    if (outs.size() >= 4) begin
      chk("starve_seg_pt3", outs[3], 12'hB00);
    end
    outs.delete();
    feed.push_back(32'h0000_0000);
    drive();
    wait_accepts(3);
    chk("underrun_sticky_in_run", Underrun, 1);
    steps(10);
    begin
      int j;
      logic [11:0] exp_resume[4];
      exp_resume = '{12'hB00, 12'hA00, 12'h900, 12'h800};
      j = 0;
      while (j < outs.size() && outs[j] == 12'hC00) j++;
      chk("resume_count", (j >= 1) && (outs.size() >= j + 4), 1);
      for (int k = 0; k < 4 && j + k < outs.size(); k++) begin
        chk($sformatf("resume_pt%0d", k), outs[j+k], exp_resume[k]);
      end
    end
    Enable = 1'b0;
    step();
    chk("underrun_kept_idle", Underrun, 1);
    Enable = 1'b1;
    step();
    chk("underrun_cleared_fill0", Underrun, 0);
    chk("fill0_s_ready", S_ready, 1);

    // Asynchronous reset while in FILL0 with a nonzero held output.
    Resetn = 1'b0;
    #2;
    chk("mid_rst_s_ready", S_ready, 0);
    chk("mid_rst_out_valid", Out_valid, 0);
    chk("mid_rst_interp_out", InterpOut, 0);
    @(negedge Fg_clk);
    Resetn = 1'b1;
    step();

    // Backpressure: S_valid held high, scoreboard on samples and all points.
    begin
      logic [31:0] xs[8];
      logic signed [63:0] a;
      logic signed [63:0] b;
      logic signed [63:0] pt;
      xs = '{32'h0000_0000, 32'h1000_0000, 32'hF000_0000, 32'h7FC0_0000,
             32'h8000_0000, 32'h2040_0000, 32'hC000_0000, 32'h0400_0000};
      restart(16'd4, 17'h04000);
      for (int i = 0; i < 8; i++) feed.push_back(xs[i]);
      drive();
      steps(45);
      chk("bp_accept_total", accepted.size(), 8);
      for (int i = 0; i < 8 && i < accepted.size(); i++) begin
        chk($sformatf("bp_accept%0d", i), accepted[i], xs[i]);
      end
      chk("bp_stalled", (stalls > 0), 1);
      chk("bp_out_count", (outs.size() >= 28), 1);
      for (int i = 0; i < 7; i++) begin
        a = 64'(signed'(xs[i]));
        b = 64'(signed'(xs[i+1]));
        for (int k = 0; k < 4; k++) begin
          pt = a + k * ((b - a) / 4);
          if (4 * i + k < outs.size()) begin
            chk($sformatf("bp_seg%0d_pt%0d", i, k), outs[4*i+k], code_of(pt[31:0]));
          end
        end
      end
    end

    // Ratio change mid-segment takes effect at the next boundary.
    restart(16'd4, 17'h04000);
    feed.push_back(32'h0000_0000);
    feed.push_back(32'h4000_0000);
    feed.push_back(32'h0000_0000);
    drive();
    wait_accepts(2);
    step();
    Ratio = 16'd8;
    Recip = 17'h02000;
    steps(20);
    begin
      logic [11:0] exp_rc[13];
      exp_rc = '{12'h800, 12'h900, 12'hA00, 12'hB00, 12'hC00, 12'hB80, 12'hB00,
                 12'hA80, 12'hA00, 12'h980, 12'h900, 12'h880, 12'h800};
      chk("rc_count", (outs.size() >= 13), 1);
      for (int i = 0; i < 13 && i < outs.size(); i++) begin
        chk($sformatf("rc_pt%0d", i), outs[i], exp_rc[i]);
      end
    end

    // Enable abort mid-segment, then restart from FILL0.
    restart(16'd4, 17'h04000);
    feed.push_back(32'h0000_0000);
    feed.push_back(32'h4000_0000);
    feed.push_back(32'h4000_0000);
    drive();
    wait_accepts(2);
    step();
    chk("lat1_valid", Out_valid, 1);
    chk("lat1_data", InterpOut, 12'h800);
    step();
    chk("lat2_data", InterpOut, 12'h900);
    Enable = 1'b0;
    step();
    chk("abort_valid", Out_valid, 0);
    chk("abort_hold", InterpOut, 12'h900);
    chk("abort_s_ready", S_ready, 0);
    steps(3);
    chk("idle_no_valid", Out_valid, 0);
    chk("idle_hold", InterpOut, 12'h900);
    restart(16'd4, 17'h04000);
    feed.push_back(32'h4000_0000);
    feed.push_back(32'h0000_0000);
    feed.push_back(32'h0000_0000);
    drive();
    steps(20);
    begin
      logic [11:0] exp_rs[5];
      exp_rs = '{12'hC00, 12'hB00, 12'hA00, 12'h900, 12'h800};
      chk("restart_count", (outs.size() >= 5), 1);
      for (int i = 0; i < 5 && i < outs.size(); i++) begin
        chk($sformatf("restart_pt%0d", i), outs[i], exp_rs[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
